// File: rtl/mem_controller.sv
// Multi-channel memory arbiter: each channel claims one requesting consumer,
// relays its read or write to memory and holds the completion until released.
module mem_controller #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int   CW    = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam logic WR_EN = (WRITE_ENABLE != 0);

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      READ_WAITING   = 3'd1,
      WRITE_WAITING  = 3'd2,
      READ_RELAYING  = 3'd3,
      WRITE_RELAYING = 3'd4
   } state_t;

   state_t                           state_q [NUM_CHANNELS];
   state_t                           state_d [NUM_CHANNELS];
   logic [CW-1:0]                    cons_q [NUM_CHANNELS];
   logic [CW-1:0]                    cons_d [NUM_CHANNELS];
   logic [CW-1:0]                    claim_idx_s [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]          claim_s, claim_rd_s;
   logic [NUM_CONSUMERS-1:0]         mask_q, mask_d, wv_s;
   logic [NUM_CHANNELS-1:0]          mrv_q, mrv_d, mwv_q, mwv_d;
   logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_q, mra_d, mwa_q, mwa_d;
   logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_q, mwd_d;
   logic [NUM_CONSUMERS-1:0]         crr_q, crr_d, cwr_q, cwr_d;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;

   assign wv_s = consumer_write_valid & {NUM_CONSUMERS{WR_EN}};

   // Claim arbitration: channels in index order each take the lowest free requester.
   always_comb begin
      logic [NUM_CONSUMERS-1:0] taken_v;
      logic                     found_v;
      taken_v    = mask_q;
      found_v    = 1'b0;
      claim_s    = '0;
      claim_rd_s = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         claim_idx_s[ch] = '0;
         found_v         = 1'b0;
         if (state_q[ch] == IDLE) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
               if (!found_v && !taken_v[i] && (consumer_read_valid[i] || wv_s[i])) begin
                  found_v         = 1'b1;
                  taken_v[i]      = 1'b1;
                  claim_s[ch]     = 1'b1;
                  claim_rd_s[ch]  = consumer_read_valid[i];
                  claim_idx_s[ch] = CW'(i);
               end else begin
                  found_v = found_v;
               end
            end
         end else begin
            found_v = 1'b0;
         end
      end
   end

   // State, owner and serving-mask registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch] <= IDLE;
            cons_q[ch]  <= '0;
         end
         mask_q <= '0;
         mrv_q  <= '0;
         mwv_q  <= '0;
         mra_q  <= '0;
         mwa_q  <= '0;
         mwd_q  <= '0;
         crr_q  <= '0;
         cwr_q  <= '0;
         crd_q  <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch] <= state_d[ch];
            cons_q[ch]  <= cons_d[ch];
         end
         mask_q <= mask_d;
         mrv_q  <= mrv_d;
         mwv_q  <= mwv_d;
         mra_q  <= mra_d;
         mwa_q  <= mwa_d;
         mwd_q  <= mwd_d;
         crr_q  <= crr_d;
         cwr_q  <= cwr_d;
         crd_q  <= crd_d;
      end
   end

   // Next-state logic per channel, including mask set on claim and clear on release.
   always_comb begin
      mask_d = mask_q;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         state_d[ch] = state_q[ch];
         cons_d[ch]  = cons_q[ch];
         case (state_q[ch])
            IDLE: begin
               if (claim_s[ch]) begin
                  state_d[ch]             = claim_rd_s[ch] ? READ_WAITING : WRITE_WAITING;
                  cons_d[ch]              = claim_idx_s[ch];
                  mask_d[claim_idx_s[ch]] = 1'b1;
               end else begin
                  state_d[ch] = IDLE;
               end
            end
            READ_WAITING: begin
               if (mem_read_ready[ch]) state_d[ch] = READ_RELAYING;
               else                    state_d[ch] = READ_WAITING;
            end
            WRITE_WAITING: begin
               if (mem_write_ready[ch]) state_d[ch] = WRITE_RELAYING;
               else                     state_d[ch] = WRITE_WAITING;
            end
            READ_RELAYING: begin
               if (!consumer_read_valid[cons_q[ch]]) begin
                  state_d[ch]        = IDLE;
                  mask_d[cons_q[ch]] = 1'b0;
               end else begin
                  state_d[ch] = READ_RELAYING;
               end
            end
            WRITE_RELAYING: begin
               if (!wv_s[cons_q[ch]]) begin
                  state_d[ch]        = IDLE;
                  mask_d[cons_q[ch]] = 1'b0;
               end else begin
                  state_d[ch] = WRITE_RELAYING;
               end
            end
            default: state_d[ch] = IDLE;
         endcase
      end
   end

   // Output next values: memory requests, consumer completions and returned data.
   always_comb begin
      mrv_d = mrv_q;
      mwv_d = mwv_q;
      mra_d = mra_q;
      mwa_d = mwa_q;
      mwd_d = mwd_q;
      crr_d = crr_q;
      cwr_d = cwr_q;
      crd_d = crd_q;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         case (state_q[ch])
            IDLE: begin
               if (claim_s[ch] && claim_rd_s[ch]) begin
                  mrv_d[ch] = 1'b1;
                  mra_d[ch*ADDR_BITS +: ADDR_BITS] =
                     consumer_read_address[claim_idx_s[ch]*ADDR_BITS +: ADDR_BITS];
               end else if (claim_s[ch]) begin
                  mwv_d[ch] = 1'b1;
                  mwa_d[ch*ADDR_BITS +: ADDR_BITS] =
                     consumer_write_address[claim_idx_s[ch]*ADDR_BITS +: ADDR_BITS];
                  mwd_d[ch*DATA_BITS +: DATA_BITS] =
                     consumer_write_data[claim_idx_s[ch]*DATA_BITS +: DATA_BITS];
               end else begin
                  mrv_d[ch] = mrv_q[ch];
               end
            end
            READ_WAITING: begin
               if (mem_read_ready[ch]) begin
                  mrv_d[ch]         = 1'b0;
                  crr_d[cons_q[ch]] = 1'b1;
                  crd_d[cons_q[ch]*DATA_BITS +: DATA_BITS] =
                     mem_read_data[ch*DATA_BITS +: DATA_BITS];
               end else begin
                  mrv_d[ch] = 1'b1;
               end
            end
            WRITE_WAITING: begin
               if (mem_write_ready[ch]) begin
                  mwv_d[ch]         = 1'b0;
                  cwr_d[cons_q[ch]] = 1'b1;
               end else begin
                  mwv_d[ch] = 1'b1;
               end
            end
            READ_RELAYING: begin
               if (!consumer_read_valid[cons_q[ch]]) crr_d[cons_q[ch]] = 1'b0;
               else                                  crr_d[cons_q[ch]] = 1'b1;
            end
            WRITE_RELAYING: begin
               if (!wv_s[cons_q[ch]]) cwr_d[cons_q[ch]] = 1'b0;
               else                   cwr_d[cons_q[ch]] = 1'b1;
            end
            default: mrv_d[ch] = 1'b0;
         endcase
      end
   end

   assign mem_read_valid       = mrv_q;
   assign mem_read_address     = mra_q;
   assign mem_write_valid      = mwv_q;
   assign mem_write_address    = mwa_q;
   assign mem_write_data       = mwd_q;
   assign consumer_read_ready  = crr_q;
   assign consumer_read_data   = crd_q;
   assign consumer_write_ready = cwr_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a one-cycle-ready memory model per channel.
module tb_mem_controller;
   localparam int AB  = 8;
   localparam int DB  = 8;
   localparam int NC  = 8;
   localparam int NCH = 4;

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [NC-1:0]   crv, crr, cwv, cwr;
   logic [NC*AB-1:0] cra, cwa;
   logic [NC*DB-1:0] crd, cwd;
   logic [NCH-1:0]  mrv, mrr, mwv, mwr;
   logic [NCH*AB-1:0] mra, mwa;
   logic [NCH*DB-1:0] mrd, mwd;
   logic            stall;
   logic [7:0]      mem [256];
   int              issue_cnt [256];
   int              tests = 0;
   int              fails = 0;

   mem_controller #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
   ) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(crv), .consumer_read_address(cra),
      .consumer_read_ready(crr), .consumer_read_data(crd),
      .consumer_write_valid(cwv), .consumer_write_address(cwa),
      .consumer_write_data(cwd), .consumer_write_ready(cwr),
      .mem_read_valid(mrv), .mem_read_address(mra),
      .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mwv), .mem_write_address(mwa),
      .mem_write_data(mwd), .mem_write_ready(mwr)
   );

   always #5 clk = ~clk;

   // Memory model: ready pulses one cycle after valid unless stalled.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mrr <= '0;
         mwr <= '0;
         mrd <= '0;
         for (int i = 0; i < 256; i++) begin
            mem[i]       <= (i == 5) ? 8'h2A : 8'(8'h40 + i);
            issue_cnt[i] <= 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            mrr[c] <= mrv[c] && !mrr[c] && !stall;
            mwr[c] <= mwv[c] && !mwr[c] && !stall;
            if (mrv[c] && !mrr[c] && !stall) begin
               mrd[c*DB +: DB] <= mem[mra[c*AB +: AB]];
               issue_cnt[mra[c*AB +: AB]] <= issue_cnt[mra[c*AB +: AB]] + 1;
            end
            if (mwv[c] && !mwr[c] && !stall) mem[mwa[c*AB +: AB]] <= mwd[c*DB +: DB];
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if ({mrv, mwv, mra, mwa, mwd, crr, cwr, crd} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, want 0", {mrv, mwv, mra, mwa, mwd, crr, cwr, crd});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({mrv, mwv} !== 8'h00) begin
         fails++;
         $display("FAIL idle_no_request: got %h, want 00", {mrv, mwv});
      end
   endtask

   task automatic test_single_read();
      crv[0] = 1'b1; cra[7:0] = 8'h05;
      @(negedge clk);
      tests++;
      if (mrv !== 4'b0001 || mra[7:0] !== 8'h05 || crr !== 8'h00) begin
         fails++;
         $display("FAIL single_issue: mrv=%b addr=%h crr=%b, want 0001 05 0", mrv, mra[7:0], crr);
      end
      @(negedge clk);
      tests++;
      if (crr !== 8'h00) begin
         fails++;
         $display("FAIL single_early_ready: got %b, want 0", crr);
      end
      @(negedge clk);
      tests++;
      if (crr !== 8'h01 || crd[7:0] !== 8'h2A || mrv !== 4'b0000) begin
         fails++;
         $display("FAIL single_done: crr=%b data=%h mrv=%b, want 01 2a 0", crr, crd[7:0], mrv);
      end
      crv[0] = 1'b0;
      @(negedge clk);
      tests++;
      if (crr !== 8'h00 || crd[7:0] !== 8'h2A) begin
         fails++;
         $display("FAIL single_release: crr=%b data=%h, want 0 2a", crr, crd[7:0]);
      end
   endtask

   task automatic test_all_read();
      int base [8];
      for (int i = 0; i < 8; i++) base[i] = issue_cnt[i];
      crv = 8'hFF; cra = 64'h0706050403020100;
      @(negedge clk);
      tests++;
      if (mrv !== 4'hF || mra !== 32'h03020100) begin
         fails++;
         $display("FAIL all_first_issue: mrv=%b addr=%h, want f 03020100", mrv, mra);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (crr !== 8'h0F || crd[31:0] !== 32'h43424140 || mrv !== 4'h0) begin
         fails++;
         $display("FAIL all_first_done: crr=%h data=%h mrv=%b, want 0f 43424140 0", crr, crd[31:0], mrv);
      end
      crv = 8'hF0;
      @(negedge clk);
      tests++;
      if (crr !== 8'h00 || mrv !== 4'h0) begin
         fails++;
         $display("FAIL all_release: crr=%h mrv=%b, want 00 0", crr, mrv);
      end
      @(negedge clk);
      tests++;
      if (mrv !== 4'hF || mra !== 32'h07060504) begin
         fails++;
         $display("FAIL all_second_issue: mrv=%b addr=%h, want f 07060504", mrv, mra);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (crr !== 8'hF0 || crd[63:32] !== 32'h47462A44) begin
         fails++;
         $display("FAIL all_second_done: crr=%h data=%h, want f0 47462a44", crr, crd[63:32]);
      end
      crv = 8'h00;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (issue_cnt[i] - base[i] !== 1) begin
            fails++;
            $display("FAIL all_issue_count[%0d]: got %0d, want 1", i, issue_cnt[i] - base[i]);
         end
      end
   endtask

   task automatic test_write();
      stall = 1'b1;
      cwv[2] = 1'b1; cwa[23:16] = 8'h10; cwd[23:16] = 8'h11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (mwv !== 4'b0001 || mwa[7:0] !== 8'h10 || mwd[7:0] !== 8'h11 || cwr !== 8'h00) begin
            fails++;
            $display("FAIL write_hold[%0d]: v=%b a=%h d=%h cwr=%h, want 0001 10 11 00", k, mwv, mwa[7:0], mwd[7:0], cwr);
         end
      end
      stall = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (cwr !== 8'h04 || mwv !== 4'b0000 || mem[8'h10] !== 8'h11) begin
         fails++;
         $display("FAIL write_done: cwr=%h mwv=%b mem=%h, want 04 0 11", cwr, mwv, mem[8'h10]);
      end
      @(negedge clk);
      tests++;
      if (cwr !== 8'h04) begin
         fails++;
         $display("FAIL write_ready_held: got %h, want 04", cwr);
      end
      cwv[2] = 1'b0;
      @(negedge clk);
      tests++;
      if (cwr !== 8'h00) begin
         fails++;
         $display("FAIL write_release: got %h, want 00", cwr);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      crv[1] = 1'b1; cra[15:8] = 8'h33;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         tests++;
         if (mrv !== 4'b0001 || mra[7:0] !== 8'h33 || crr !== 8'h00) begin
            fails++;
            $display("FAIL stall_hold[%0d]: v=%b a=%h crr=%h, want 0001 33 00", k, mrv, mra[7:0], crr);
         end
      end
      stall = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (crr !== 8'h02 || crd[15:8] !== 8'h73) begin
         fails++;
         $display("FAIL stall_done: crr=%h data=%h, want 02 73", crr, crd[15:8]);
      end
      crv[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      stall = 1'b1;
      crv[3] = 1'b1; cra[31:24] = 8'h07;
      @(negedge clk);
      tests++;
      if (mrv !== 4'b0001 || mra[7:0] !== 8'h07) begin
         fails++;
         $display("FAIL rstmid_issue: v=%b a=%h, want 0001 07", mrv, mra[7:0]);
      end
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({mrv, mwv, mra, mwa, mwd, crr, cwr, crd} !== '0) begin
         fails++;
         $display("FAIL rstmid_async_clear: got %h, want 0", {mrv, mwv, mra, mwa, mwd, crr, cwr, crd});
      end
      @(negedge clk);
      reset = 1'b1; stall = 1'b0;
      #1;
      tests++;
      if (mrv !== 4'b0000) begin
         fails++;
         $display("FAIL rstmid_no_early_issue: got %b, want 0000", mrv);
      end
      @(negedge clk);
      tests++;
      if (mrv !== 4'b0001 || mra[7:0] !== 8'h07) begin
         fails++;
         $display("FAIL rstmid_reissue: v=%b a=%h, want 0001 07", mrv, mra[7:0]);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (crr !== 8'h08 || crd[31:24] !== 8'h47) begin
         fails++;
         $display("FAIL rstmid_done: crr=%h data=%h, want 08 47", crr, crd[31:24]);
      end
      crv[3] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hold();
      crv[6] = 1'b1; cra[55:48] = 8'h06;
      repeat (3) @(negedge clk);
      tests++;
      if (crr !== 8'h40 || crd[55:48] !== 8'h46) begin
         fails++;
         $display("FAIL hold_done: crr=%h data=%h, want 40 46", crr, crd[55:48]);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests++;
         if (crr !== 8'h40 || mrv !== 4'b0000) begin
            fails++;
            $display("FAIL hold_relay[%0d]: crr=%h mrv=%b, want 40 0", k, crr, mrv);
         end
      end
      crv[6] = 1'b0;
      @(negedge clk);
      tests++;
      if (crr !== 8'h00) begin
         fails++;
         $display("FAIL hold_release: got %h, want 00", crr);
      end
      crv[6] = 1'b1; cra[55:48] = 8'h08;
      @(negedge clk);
      tests++;
      if (mrv !== 4'b0001 || mra[7:0] !== 8'h08) begin
         fails++;
         $display("FAIL hold_back_to_idle: v=%b a=%h, want 0001 08", mrv, mra[7:0]);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (crr !== 8'h40 || crd[55:48] !== 8'h48) begin
         fails++;
         $display("FAIL hold_second_read: crr=%h data=%h, want 40 48", crr, crd[55:48]);
      end
      crv[6] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      crv = '0; cra = '0; cwv = '0; cwa = '0; cwd = '0; stall = 1'b0;
      test_reset();
      test_single_read();
      test_all_read();
      test_write();
      test_stall();
      test_reset_mid();
      test_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
